// File: rtl/axil_slave_regfile.sv
// axil_slave_regfile: AXI4-Lite slave exposing NUM_REGS 32-bit R/W registers; AXIL_REGFILE_WR_PULSE_EN adds wr_pulse
module axil_slave_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS = 4
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_q
`ifdef AXIL_REGFILE_WR_PULSE_EN
  ,
  output logic [NUM_REGS-1:0]                    wr_pulse
`endif
);
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_VALID} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic rst_done;
  logic aw_hs, w_hs, ar_hs, commit, w_ok, r_ok;
  logic [IW-1:0] aw_idx_q, w_idx, r_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, w_data, r_val;
  logic [SW-1:0] wstrb_q, w_strb;
  logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] regs;
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  // The commit edge is the one completing the second of AW/W, so the missing half is taken live from the bus
  assign commit = (w_next == W_RESP) && (w_state != W_RESP);
  assign w_idx = (w_state == W_HAVE_A) ? aw_idx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_data = (w_state == W_HAVE_D) ? wdata_q : S_AXI_WDATA;
  assign w_strb = (w_state == W_HAVE_D) ? wstrb_q : S_AXI_WSTRB;
  assign r_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_ok = 32'(w_idx) < 32'(NUM_REGS);
  assign r_ok = 32'(r_idx) < 32'(NUM_REGS);
  assign reg_q = regs;

  // Readies stay low until the first clock edge after reset release
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) rst_done <= 1'b0;
    else rst_done <= 1'b1;

  // Write channel state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) w_state <= W_IDLE;
    else w_state <= w_next;

  // Write channel next state: AW and W may arrive in either order or together
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:   w_next = (aw_hs && w_hs) ? W_RESP : aw_hs ? W_HAVE_A : w_hs ? W_HAVE_D : W_IDLE;
      W_HAVE_A: w_next = w_hs ? W_RESP : W_HAVE_A;
      W_HAVE_D: w_next = aw_hs ? W_RESP : W_HAVE_D;
      default:  w_next = S_AXI_BREADY ? W_IDLE : W_RESP;
    endcase
  end

  // Write channel outputs: each half is accepted once and nothing new while B is pending
  always_comb begin
    S_AXI_AWREADY = rst_done && (w_state == W_IDLE || w_state == W_HAVE_D);
    S_AXI_WREADY = rst_done && (w_state == W_IDLE || w_state == W_HAVE_A);
    S_AXI_BVALID = w_state == W_RESP;
  end

  // Latch whichever write half arrives first
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      aw_idx_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end

  // Write response is fixed at commit and held until BREADY
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) S_AXI_BRESP <= 2'b00;
    else if (commit) S_AXI_BRESP <= w_ok ? 2'b00 : 2'b10;

  // Byte-enabled register update; out-of-range indices change nothing
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) regs <= '0;
    else if (commit && w_ok)
      for (int i = 0; i < NUM_REGS; i++)
        for (int b = 0; b < SW; b++)
          if (w_idx == IW'(i) && w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];

`ifdef AXIL_REGFILE_WR_PULSE_EN
  // One-cycle strobe per register after each successful commit
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) wr_pulse <= '0;
    else
      for (int i = 0; i < NUM_REGS; i++)
        wr_pulse[i] <= commit && w_ok && (w_idx == IW'(i));
`endif

  // Read channel state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) r_state <= R_IDLE;
    else r_state <= r_next;

  // Read channel next state
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  r_next = ar_hs ? R_VALID : R_IDLE;
      default: r_next = S_AXI_RREADY ? R_IDLE : R_VALID;
    endcase
  end

  // Read channel outputs
  always_comb begin
    S_AXI_ARREADY = rst_done && (r_state == R_IDLE);
    S_AXI_RVALID = r_state == R_VALID;
  end

  // Read mux; unimplemented indices read as zero
  always_comb begin
    r_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (r_idx == IW'(i)) r_val = regs[i];
  end

  // Read data captured at the AR handshake, so a same-edge commit yields the old value
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= 2'b00;
    end else if (ar_hs) begin
      S_AXI_RDATA <= r_val;
      S_AXI_RRESP <= r_ok ? 2'b00 : 2'b10;
    end
endmodule

// File: tb/tb_axil_slave_regfile.sv
// tb_axil_slave_regfile: table-driven scoreboard bench for axil_slave_regfile (4- and 3-register builds side by side)
module tb_axil_slave_regfile;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] awaddr = '0, araddr = '0, wstrb = '0;
  logic [31:0] wdata = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [127:0] reg_q;
  logic awready3, wready3, bvalid3, arready3, rvalid3;
  logic [1:0] bresp3, rresp3;
  logic [31:0] rdata3;
  logic [95:0] reg_q3;
`ifdef AXIL_REGFILE_WR_PULSE_EN
  logic [3:0] wr_pulse;
  logic [2:0] wr_pulse3;
`endif

  axil_slave_regfile #(.NUM_REGS(4)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_q(reg_q)
`ifdef AXIL_REGFILE_WR_PULSE_EN
    , .wr_pulse(wr_pulse)
`endif
  );

  axil_slave_regfile #(.NUM_REGS(3)) dut3 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready3),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready3),
    .S_AXI_BRESP(bresp3), .S_AXI_BVALID(bvalid3), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready3),
    .S_AXI_RDATA(rdata3), .S_AXI_RRESP(rresp3), .S_AXI_RVALID(rvalid3), .S_AXI_RREADY(rready),
    .reg_q(reg_q3)
`ifdef AXIL_REGFILE_WR_PULSE_EN
    , .wr_pulse(wr_pulse3)
`endif
  );

  typedef struct {
    bit rd;
    logic [3:0] a;
    logic [31:0] d;
    logic [3:0] s;
    int lead;
    int dly;
    logic [1:0] er;
    logic [31:0] ed;
    logic [1:0] er3;
    logic [31:0] ed3;
  } vec_t;

  typedef struct {
    logic [1:0] r;
    logic [31:0] d;
    logic [1:0] r3;
    logic [31:0] d3;
  } exp_t;

  exp_t exp_q[$];
  vec_t v[0:22];
  int errs = 0, checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic push_exp(input logic [1:0] r, input logic [31:0] d, input logic [1:0] r3, input logic [31:0] d3);
    exp_t e;
    e.r = r; e.d = d; e.r3 = r3; e.d3 = d3;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input int lead, input int dly,
                    input logic [1:0] er, input logic [1:0] er3);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_go, w_go, held_ok = 1, stable = 1;
    logic [1:0] r0;
    exp_t e;
    push_exp(er, 32'h0, er3, 32'h0);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    if (lead >= 0) wvalid = 1;
    if (lead <= 0) awvalid = 1;
    while (!(aw_done && w_done) && cyc < 50) begin
      aw_go = awvalid & awready;
      w_go = wvalid & wready;
      @(posedge clk); #1;
      if (aw_go) begin awvalid = 0; aw_done = 1; end
      if (w_go) begin wvalid = 0; w_done = 1; end
      cyc++;
      if (lead > 0 && cyc == lead) awvalid = 1;
      if (lead < 0 && cyc == -lead) wvalid = 1;
      @(negedge clk);
      if (w_done && !aw_done && (wready || bvalid)) held_ok = 0;
      if (aw_done && !w_done && (awready || bvalid)) held_ok = 0;
    end
    check("b_latency", {bvalid, bvalid3}, 2'b11);
    if (lead != 0) check("half_held", held_ok, 1'b1);
    r0 = bresp;
    for (int i = 0; i < dly; i++) begin
      if (!bvalid || bresp !== r0 || awready || wready) stable = 0;
      @(negedge clk);
    end
    if (dly > 0) check("b_stall", {stable, bvalid, bresp}, {1'b1, 1'b1, r0});
    e = exp_q.pop_front();
    check("bresp", bresp, e.r);
    check("bresp3", bresp3, e.r3);
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    @(negedge clk);
    check("b_clear", {bvalid, awready, wready}, 3'b011);
  endtask

  task automatic rd(input logic [3:0] a, input int dly, input logic [1:0] er, input logic [31:0] ed,
                    input logic [1:0] er3, input logic [31:0] ed3);
    int cyc = 0;
    bit stable = 1;
    logic [31:0] d0;
    exp_t e;
    push_exp(er, ed, er3, ed3);
    @(negedge clk);
    araddr = a; arvalid = 1;
    while (!arready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1;
    arvalid = 0;
    @(negedge clk);
    check("r_latency", {rvalid, rvalid3, arready}, 3'b110);
    d0 = rdata;
    for (int i = 0; i < dly; i++) begin
      if (!rvalid || rdata !== d0 || arready) stable = 0;
      @(negedge clk);
    end
    if (dly > 0) check("r_stall", {stable, rdata}, {1'b1, d0});
    e = exp_q.pop_front();
    check("rresp", rresp, e.r);
    check("rdata", rdata, e.d);
    check("rresp3", rresp3, e.r3);
    check("rdata3", rdata3, e.d3);
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    @(negedge clk);
    check("r_clear", {rvalid, arready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          rd a     d             s     lead dly er     ed            er3    ed3
    v[0]  = '{0, 4'h0, 32'h00000001, 4'hF, 0,  0, 2'b00, 32'h0,        2'b00, 32'h0};
    v[1]  = '{0, 4'h4, 32'h00000002, 4'hF, 0,  0, 2'b00, 32'h0,        2'b00, 32'h0};
    v[2]  = '{0, 4'h8, 32'h00000003, 4'hF, 0,  0, 2'b00, 32'h0,        2'b00, 32'h0};
    v[3]  = '{0, 4'hC, 32'h00000004, 4'hF, 0,  0, 2'b00, 32'h0,        2'b10, 32'h0};
    v[4]  = '{1, 4'h0, 32'h0,        4'h0, 0,  0, 2'b00, 32'h00000001, 2'b00, 32'h00000001};
    v[5]  = '{1, 4'h4, 32'h0,        4'h0, 0,  0, 2'b00, 32'h00000002, 2'b00, 32'h00000002};
    v[6]  = '{1, 4'h8, 32'h0,        4'h0, 0,  0, 2'b00, 32'h00000003, 2'b00, 32'h00000003};
    v[7]  = '{1, 4'hC, 32'h0,        4'h0, 0,  0, 2'b00, 32'h00000004, 2'b10, 32'h0};
    v[8]  = '{0, 4'h0, 32'hAABBCCDD, 4'hF, 0,  0, 2'b00, 32'h0,        2'b00, 32'h0};
    v[9]  = '{0, 4'h0, 32'h11223344, 4'h5, 0,  0, 2'b00, 32'h0,        2'b00, 32'h0};
    v[10] = '{1, 4'h0, 32'h0,        4'h0, 0,  0, 2'b00, 32'hAA22CC44, 2'b00, 32'hAA22CC44};
    v[11] = '{0, 4'h8, 32'hDEADBEEF, 4'hF, 3,  0, 2'b00, 32'h0,        2'b00, 32'h0};
    v[12] = '{1, 4'h8, 32'h0,        4'h0, 0,  0, 2'b00, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF};
    v[13] = '{0, 4'h4, 32'h12345678, 4'hF, 0,  5, 2'b00, 32'h0,        2'b00, 32'h0};
    v[14] = '{1, 4'h4, 32'h0,        4'h0, 0,  3, 2'b00, 32'h12345678, 2'b00, 32'h12345678};
    v[15] = '{0, 4'h4, 32'hFFFFFFFF, 4'h0, 0,  0, 2'b00, 32'h0,        2'b00, 32'h0};
    v[16] = '{1, 4'h4, 32'h0,        4'h0, 0,  0, 2'b00, 32'h12345678, 2'b00, 32'h12345678};
    v[17] = '{0, 4'h5, 32'h000000AB, 4'h1, 0,  0, 2'b00, 32'h0,        2'b00, 32'h0};
    v[18] = '{1, 4'h7, 32'h0,        4'h0, 0,  0, 2'b00, 32'h123456AB, 2'b00, 32'h123456AB};
    v[19] = '{1, 4'hC, 32'h0,        4'h0, 0,  2, 2'b00, 32'h00000004, 2'b10, 32'h0};
    v[20] = '{0, 4'hC, 32'h00000099, 4'hF, -2, 0, 2'b00, 32'h0,        2'b10, 32'h0};
    v[21] = '{1, 4'hC, 32'h0,        4'h0, 0,  0, 2'b00, 32'h00000099, 2'b10, 32'h0};
    v[22] = '{1, 4'h0, 32'h0,        4'h0, 0,  0, 2'b00, 32'hAA22CC44, 2'b00, 32'hAA22CC44};

    repeat (3) @(negedge clk);
    check("rst_valids", {bvalid, rvalid, bvalid3, rvalid3}, 4'b0);
    check("rst_readies", {awready, wready, arready}, 3'b0);
    check("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
    check("rst_regs", {reg_q, reg_q3}, 224'h0);
    rst_n = 1;
    #1;
    check("readies_pre_edge", {awready, wready, arready}, 3'b0);
    @(negedge clk);
    check("readies_post_edge", {awready, wready, arready}, 3'b111);

    for (int i = 0; i <= 22; i++)
      if (v[i].rd) rd(v[i].a, v[i].dly, v[i].er, v[i].ed, v[i].er3, v[i].ed3);
      else wr(v[i].a, v[i].d, v[i].s, v[i].lead, v[i].dly, v[i].er, v[i].er3);

    check("reg_q", reg_q, {32'h00000099, 32'hDEADBEEF, 32'h123456AB, 32'hAA22CC44});
    check("reg_q3", reg_q3, {32'hDEADBEEF, 32'h123456AB, 32'hAA22CC44});

    // AR sampled on the commit edge to the same register sees the old value
    @(negedge clk);
    awaddr = 4'h8; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 4'h8; arvalid = 1; bready = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    check("sim_valids", {bvalid, rvalid}, 2'b11);
    check("sim_old_data", {rdata, rdata3}, {32'hDEADBEEF, 32'hDEADBEEF});
    check("sim_reg_updated", reg_q[95:64], 32'h0BADF00D);
    rready = 1;
    @(posedge clk); #1;
    rready = 0; bready = 0;
    rd(4'h8, 0, 2'b00, 32'h0BADF00D, 2'b00, 32'h0BADF00D);

`ifdef AXIL_REGFILE_WR_PULSE_EN
    @(negedge clk);
    awaddr = 4'h4; wdata = 32'h5; wstrb = 4'h0; awvalid = 1; wvalid = 1; bready = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    check("pulse_on", {wr_pulse, wr_pulse3}, {4'b0010, 3'b010});
    @(posedge clk); #1;
    @(negedge clk);
    check("pulse_off", {wr_pulse, wr_pulse3}, 7'b0);
    awaddr = 4'hC; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    check("pulse_slverr", {wr_pulse, wr_pulse3}, {4'b1000, 3'b000});
    @(posedge clk); #1;
    bready = 0;
    @(negedge clk);
`endif

    // Reset while W is held and R is pending abandons both
    @(negedge clk);
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1; araddr = 4'h0; arvalid = 1;
    @(posedge clk); #1;
    wvalid = 0; arvalid = 0;
    @(negedge clk);
    check("pre_rst_state", {wready, rvalid}, 2'b01);
    rst_n = 0;
    #1;
    check("mid_rst_valids", {bvalid, rvalid, bvalid3, rvalid3}, 4'b0);
    check("mid_rst_out", {rdata, reg_q, reg_q3}, 256'h0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("post_rst_readies", {awready, wready, arready, bvalid}, 4'b1110);
    rd(4'h0, 0, 2'b00, 32'h0, 2'b00, 32'h0);
    rd(4'h8, 0, 2'b00, 32'h0, 2'b00, 32'h0);
    wr(4'h4, 32'h77, 4'hF, 0, 0, 2'b00, 2'b00);
    rd(4'h4, 0, 2'b00, 32'h77, 2'b00, 32'h77);
    check("post_rst_regs", reg_q, {32'h0, 32'h0, 32'h77, 32'h0});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
